// File: rtl/symstream_pkg.sv
// Shared types, default lane geometry and a counter-width helper for the symbol streamer.
package symstream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   localparam int DEF_SYM_W = 2;
   localparam int DEF_CH    = 1;

   // Width of a counter spanning 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sym_unpacker.sv
// One-word holding register with a step pointer; serves MSB-first slices of the held word,
// or of the word being accepted this cycle when the register is empty.
module sym_unpacker
   import symstream_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int STEP_W = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_acc,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_load,
   output logic [STEP_W-1:0] o_slice,
   output logic              o_empty,
   output logic              o_last
);
   localparam int S     = WORD_W / STEP_W;
   localparam int PTR_W = cnt_w(S);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(S - 1);

   logic [WORD_W-1:0] r_word;
   logic [PTR_W-1:0]  r_ptr;
   logic              r_full;
   logic [WORD_W-1:0] w_src;
   logic [WORD_W-1:0] w_shifted;
   logic [PTR_W-1:0]  w_ptr;
   logic              w_src_last;

   // Select held word or bypass the incoming one, then pick the current slice.
   always_comb begin
      if (r_full) begin
         w_src = r_word;
         w_ptr = r_ptr;
      end else begin
         w_src = i_word;
         w_ptr = {PTR_W{1'b0}};
      end
      w_shifted  = w_src << (int'(w_ptr) * STEP_W);
      w_src_last = (w_ptr == PTR_LAST);
   end

   assign o_slice = w_shifted[WORD_W-1 -: STEP_W];
   assign o_empty = ~r_full;
   assign o_last  = r_full && (r_ptr == PTR_LAST);

   // Word register and step pointer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word <= {WORD_W{1'b0}};
         r_ptr  <= {PTR_W{1'b0}};
         r_full <= 1'b0;
      end else if (i_clr) begin
         r_word <= {WORD_W{1'b0}};
         r_ptr  <= {PTR_W{1'b0}};
         r_full <= 1'b0;
      end else if (i_load) begin
         if (!w_src_last) begin
            r_word <= w_src;
            r_ptr  <= w_ptr + PTR_W'(1);
            r_full <= 1'b1;
         end else if (i_acc && r_full) begin
            // last slice of the held word leaves while its successor arrives
            r_word <= i_word;
            r_ptr  <= {PTR_W{1'b0}};
            r_full <= 1'b1;
         end else begin
            r_ptr  <= {PTR_W{1'b0}};
            r_full <= 1'b0;
         end
      end else if (i_acc) begin
         r_word <= i_word;
         r_ptr  <= {PTR_W{1'b0}};
         r_full <= 1'b1;
      end
   end

endmodule

// File: rtl/symbol_streamer.sv
// Streams packed words out as CH-lane symbol steps, each held HOLD cycles, then a TAIL-cycle
// flush and a done pulse. Starvation stalls the stream and sets a sticky underrun flag.
module symbol_streamer
   import symstream_pkg::*;
#(
   parameter int SYM_W  = DEF_SYM_W,
   parameter int CH     = DEF_CH,
   parameter int WORD_W = 32,
   parameter int HOLD   = 2,
   parameter int TAIL   = 86,
   parameter int LEN_W  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [LEN_W-1:0]      i_seq_len,
   input  logic                  i_in_valid,
   input  logic [WORD_W-1:0]     i_in_data,
   output logic                  o_in_ready,
   output logic [CH*SYM_W-1:0]   o_symbol,
   output logic                  o_sym_valid,
   output logic                  o_bc_mode,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_underrun
);
   localparam int STEP_W = CH * SYM_W;
   localparam int HOLD_W = cnt_w(HOLD);
   localparam int TAIL_W = cnt_w(TAIL + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
   localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LEN_W-1:0]    r_remaining;
   logic [HOLD_W-1:0]   r_hold;
   logic [TAIL_W-1:0]   r_tail;
   logic [TAIL_W-1:0]   w_tail_nxt;
   logic                r_loaded;
   logic [STEP_W-1:0]   r_symbol;
   logic                r_sym_valid;
   logic                r_bc_mode;
   logic                r_busy;
   logic                r_done;
   logic                r_underrun;
   logic                w_due;
   logic                w_empty;
   logic                w_last;
   logic                w_in_ready;
   logic                w_acc;
   logic                w_load;
   logic                w_stall;
   logic                w_start;
   logic [STEP_W-1:0]   w_slice;

   assign w_due   = ~r_loaded || (r_hold == HOLD_LAST);
   assign w_start = (r_state == ST_IDLE) && i_start;
   // Only ask for a word while at least one more step still needs one.
   assign w_in_ready = (r_state == ST_STREAM) &&
                       (w_empty ? (r_remaining != {LEN_W{1'b0}})
                                : (w_due && w_last && (r_remaining > LEN_W'(1))));
   assign w_acc      = i_in_valid && w_in_ready;

   sym_unpacker #(
      .WORD_W (WORD_W),
      .STEP_W (STEP_W)
   ) u_unpacker (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_state_nxt != ST_STREAM),
      .i_acc   (w_acc),
      .i_word  (i_in_data),
      .i_load  (w_load),
      .o_slice (w_slice),
      .o_empty (w_empty),
      .o_last  (w_last)
   );

   // Next-state and step/stall decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_tail_nxt  = {TAIL_W{1'b0}};
      w_load      = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_seq_len == {LEN_W{1'b0}}) w_state_nxt = ST_FLUSH;
               else                            w_state_nxt = ST_STREAM;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (!w_due)                                  w_state_nxt = ST_STREAM;
            else if (r_remaining == {LEN_W{1'b0}})       w_state_nxt = ST_FLUSH;
            else if (!w_empty || w_acc)                  w_load      = 1'b1;
            else                                         w_stall     = 1'b1;
         end
         ST_FLUSH: begin
            if (r_tail == TAIL_LAST) w_state_nxt = ST_IDLE;
            else                     w_tail_nxt  = r_tail + TAIL_W'(1);
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_remaining <= {LEN_W{1'b0}};
         r_hold      <= {HOLD_W{1'b0}};
         r_tail      <= {TAIL_W{1'b0}};
         r_loaded    <= 1'b0;
         r_symbol    <= {STEP_W{1'b0}};
         r_sym_valid <= 1'b0;
         r_bc_mode   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tail      <= w_tail_nxt;
         r_done      <= (w_state_nxt == ST_FLUSH) && (w_tail_nxt == TAIL_LAST);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_bc_mode   <= (r_state == ST_STREAM) && (w_state_nxt == ST_STREAM);
         r_sym_valid <= w_load;
         if (w_state_nxt != ST_STREAM) r_symbol <= {STEP_W{1'b0}};
         else if (w_load)              r_symbol <= w_slice;
         if (w_start) begin
            r_remaining <= i_seq_len;
            r_hold      <= {HOLD_W{1'b0}};
            r_loaded    <= 1'b0;
            r_underrun  <= 1'b0;
         end else if (w_load) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_hold      <= {HOLD_W{1'b0}};
            r_loaded    <= 1'b1;
         end else if (w_stall) begin
            r_underrun  <= 1'b1;
         end else if ((r_state == ST_STREAM) && !w_due) begin
            r_hold      <= r_hold + HOLD_W'(1);
         end
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_symbol    = r_symbol;
   assign o_sym_valid = r_sym_valid;
   assign o_bc_mode   = r_bc_mode;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_symbol_streamer.sv
// Randomized bench: expected steps come from slicing the accepted words; timing from step arithmetic.
module tb_symbol_streamer;
   localparam int SYM_W  = 2;
   localparam int CH     = 1;
   localparam int WORD_W = 8;
   localparam int HOLD   = 2;
   localparam int TAIL   = 5;
   localparam int LEN_W  = 4;
   localparam int STEP_W = SYM_W * CH;
   localparam int S      = WORD_W / STEP_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  seq_len = 4'd0;
   logic              in_valid = 1'b0;
   logic [WORD_W-1:0] in_data = 8'd0;
   logic              in_ready;
   logic [STEP_W-1:0] symbol;
   logic              sym_valid, bc_mode, busy, done, underrun;

   logic              st2 = 1'b0;
   logic [LEN_W-1:0]  len2 = 4'd0;
   logic              v2 = 1'b0;
   logic [7:0]        d2 = 8'd0;
   logic              rdy2, sv2, bc2, busy2, done2, un2;
   logic [3:0]        sym2;

   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   logic [7:0]  acc_q[$];

   always #5 clk = ~clk;

   symbol_streamer #(.SYM_W(SYM_W), .CH(CH), .WORD_W(WORD_W), .HOLD(HOLD), .TAIL(TAIL), .LEN_W(LEN_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_seq_len(seq_len), .i_in_valid(in_valid),
      .i_in_data(in_data), .o_in_ready(in_ready), .o_symbol(symbol), .o_sym_valid(sym_valid),
      .o_bc_mode(bc_mode), .o_busy(busy), .o_done(done), .o_underrun(underrun));

   symbol_streamer #(.SYM_W(2), .CH(2), .WORD_W(8), .HOLD(1), .TAIL(0), .LEN_W(LEN_W)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(st2), .i_seq_len(len2), .i_in_valid(v2),
      .i_in_data(d2), .o_in_ready(rdy2), .o_symbol(sym2), .o_sym_valid(sv2),
      .o_bc_mode(bc2), .o_busy(busy2), .o_done(done2), .o_underrun(un2));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // n-th step of the sequence: slice n%S (MSB-first) of the (n/S)-th accepted word.
   function automatic logic [7:0] exp_step(input int n);
      logic [7:0] w;
      if (n / S >= acc_q.size()) return 8'hFF;
      w = acc_q[n / S];
      return (w >> ((S - 1 - (n % S)) * STEP_W)) & 8'((1 << STEP_W) - 1);
   endfunction

   task automatic tick();
      if (in_valid && in_ready) acc_q.push_back(in_data);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // mode 0: in_valid always high, 1: 5-cycle gap, 2: random valid + stray starts
   task automatic run_seq(input int len, input int mode, input int fixed);
      int c, sv, bc_cnt, d, flush0;
      logic [7:0] ex, last_ex;
      logic got_done;
      acc_q.delete();
      sv = 0; bc_cnt = 0; d = 0; got_done = 1'b0; last_ex = 8'd0;
      flush0 = (len == 0) ? cyc + 1 : cyc + 2 + len * HOLD;
      c = cyc;
      start = 1'b1;
      seq_len = LEN_W'(len);
      in_valid = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
      in_data = (fixed >= 0) ? 8'(fixed) : 8'($urandom);
      for (int k = 0; k < 400; k++) begin
         tick();
         if (bc_mode) bc_cnt++;
         if (sym_valid) begin
            ex = exp_step(sv);
            check_val("symbol", 32'(symbol), 32'(ex));
            if (mode == 0) check_val("step_cycle", cyc, c + 2 + sv * HOLD);
            last_ex = ex;
            sv++;
         end else if (bc_mode && sv > 0) begin
            check_val("frozen", 32'(symbol), 32'(last_ex));
         end
         if (!bc_mode) check_val("sym_zero", 32'(symbol), 32'd0);
         if (mode == 0 && cyc >= flush0) check_val("ready_flush", 32'(in_ready), 32'd0);
         if (done) begin
            got_done = 1'b1;
            d = cyc;
            break;
         end
         start = (mode == 2) && ($urandom_range(7) == 0);
         seq_len = LEN_W'($urandom);
         if (mode == 1) in_valid = ((cyc - c) < 5) || ((cyc - c) >= 10);
         else if (mode == 2) in_valid = ($urandom_range(3) != 0);
         else in_valid = 1'b1;
         in_data = (fixed >= 0) ? 8'(fixed) : 8'($urandom);
      end
      check_val("done_seen", 32'(got_done), 32'd1);
      check_val("step_count", sv, len);
      if (mode == 0) begin
         check_val("done_cycle", d, (len == 0) ? c + 1 + TAIL : c + 2 + len * HOLD + TAIL);
         check_val("bc_cycles", bc_cnt, len * HOLD);
         check_val("underrun0", 32'(underrun), 32'd0);
      end
      if (mode == 1) check_val("underrun1", 32'(underrun), 32'd1);
      start = 1'b0;
      in_valid = 1'b0;
      tick();
      check_val("done_pulse", 32'(done), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_symbol"}, 32'(symbol), 32'd0);
      check_val({tag, "_symvalid"}, 32'(sym_valid), 32'd0);
      check_val({tag, "_bc"}, 32'(bc_mode), 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_done"}, 32'(done), 32'd0);
      check_val({tag, "_underrun"}, 32'(underrun), 32'd0);
      check_val({tag, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      int c2;
      repeat (3) tick();
      check_reset_outs("rst");
      rst_n = 1'b1;
      tick();

      run_seq(4, 0, 8'h1B);
      run_seq(0, 0, -1);
      run_seq(3, 0, -1);
      run_seq(15, 0, -1);
      run_seq(8, 1, -1);
      for (int i = 0; i < 6; i++) run_seq($urandom_range(15, 1), 2, -1);

      // reset in the middle of a stream
      start = 1'b1; seq_len = 4'd8; in_valid = 1'b1; in_data = 8'($urandom);
      tick();
      start = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      check_reset_outs("midrst");
      for (int i = 0; i < 2; i++) begin
         tick();
         check_val("midrst_nodone", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick();
      check_val("postrst_busy", 32'(busy), 32'd0);
      run_seq(5, 0, -1);

      // two-lane instance, single-cycle hold, zero tail
      st2 = 1'b1; len2 = 4'd2; v2 = 1'b1; d2 = 8'hE4;
      c2 = cyc;
      tick();
      st2 = 1'b0;
      tick();
      v2 = 1'b0;
      check_val("l2_sv0", 32'(sv2), 32'd1);
      check_val("l2_sym0", 32'(sym2), 32'hE);
      check_val("l2_bc0", 32'(bc2), 32'd1);
      tick();
      check_val("l2_sv1", 32'(sv2), 32'd1);
      check_val("l2_sym1", 32'(sym2), 32'h4);
      tick();
      check_val("l2_done_cyc", cyc, c2 + 4);
      check_val("l2_done", 32'(done2), 32'd1);
      check_val("l2_bc_off", 32'(bc2), 32'd0);
      check_val("l2_sym_zero", 32'(sym2), 32'd0);
      check_val("l2_ready", 32'(rdy2), 32'd0);
      tick();
      check_val("l2_done_pulse", 32'(done2), 32'd0);
      check_val("l2_busy", 32'(busy2), 32'd0);
      check_val("l2_underrun", 32'(un2), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
